// File: rtl/decoder_pkg.sv
// Shared decoder definitions: default select width and a one-hot decode helper.
package decoder_pkg;

  localparam int unsigned DefaultSelW = 2;
  localparam int unsigned DefaultOutW = 2 ** DefaultSelW;

  // Returns 1 << sel at the default output width.
  function automatic logic [DefaultOutW-1:0] onehot_decode(input logic [DefaultSelW-1:0] sel);
    logic [DefaultOutW-1:0] one;
    one = DefaultOutW'(1);
    return one << sel;
  endfunction

endpackage

// File: rtl/decoder_core.sv
// Combinational decode stage: one-hot of the select when enabled, zero otherwise.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W = DefaultSelW,
  localparam int unsigned OUT_W = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] A,
  input  logic             E,
  output logic [OUT_W-1:0] y_next
);

  // Per-bit compare keeps the decode a single level for any SEL_W.
  always_comb begin
    y_next = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      y_next[i] = E && (A == SEL_W'(i));
    end
  end

endmodule

// File: rtl/decoder_2to4.sv
// Registered 2-to-4 decoder: decode stage followed by an output register with sync reset.
module decoder_2to4
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W = DefaultSelW,
  localparam int unsigned OUT_W = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] A,
  input  logic             E,
  output logic [OUT_W-1:0] Y
);

  logic [OUT_W-1:0] y_d;
  logic [OUT_W-1:0] y_q;

  decoder_core #(
    .SEL_W(SEL_W)
  ) u_core (
    .A     (A),
    .E     (E),
    .y_next(y_d)
  );

  // Output register; reset takes priority over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign Y = y_q;

`ifndef SYNTHESIS
  // Output never has more than one bit set.
  assert property (@(posedge clk) $isunknown(Y) || $onehot0(Y))
    else $error("decoder_2to4: Y not one-hot-or-zero: %b", Y);

  // A reset edge always leaves the output cleared.
  assert property (@(posedge clk) rst |=> (Y == '0))
    else $error("decoder_2to4: Y nonzero after reset: %b", Y);
`endif

endmodule

// File: tb/tb_decoder_2to4.sv
// Directed self-checking bench for decoder_2to4.
module tb_decoder_2to4;

  logic       clk;
  logic       rst;
  logic [1:0] A;
  logic       E;
  logic [3:0] Y;

  int n_tests;
  int n_fail;

  decoder_2to4 u_dut (
    .clk(clk),
    .rst(rst),
    .A  (A),
    .E  (E),
    .Y  (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  logic [1:0] seq3_a [4];
  logic [3:0] seq3_y [4];
  logic [1:0] seq4_a [8];
  logic [3:0] seq4_y [8];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    seq3_a = '{2'b00, 2'b01, 2'b11, 2'b10};
    seq3_y = '{4'b0001, 4'b0010, 4'b1000, 4'b0100};
    seq4_a = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
    seq4_y = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

    // 1: reset held two cycles with enable and A=11, reset wins.
    rst = 1'b1;
    E   = 1'b1;
    A   = 2'b11;
    tick();
    check_eq("rst_cycle1", Y, 4'b0000);
    tick();
    check_eq("rst_cycle2", Y, 4'b0000);
    rst = 1'b0;
    tick();
    check_eq("rst_release", Y, 4'b1000);

    // 2: disabled gives zero, enabling decodes at the next edge.
    E = 1'b0;
    A = 2'b00;
    tick();
    check_eq("disabled", Y, 4'b0000);
    E = 1'b1;
    #1;
    check_eq("enable_pre_edge", Y, 4'b0000);
    tick();
    check_eq("enable_a00", Y, 4'b0001);

    // 3: step A, holding each value; old value persists until the edge.
    for (int i = 0; i < 4; i++) begin
      logic [3:0] prev;
      prev = Y;
      A = seq3_a[i];
      #1;
      check_eq($sformatf("hold_pre_%0d", i), Y, prev);
      for (int c = 0; c < 3; c++) begin
        tick();
        check_eq($sformatf("hold_a%0d_c%0d", i, c), Y, seq3_y[i]);
      end
    end

    // 4: A changes every cycle, back to back.
    for (int i = 0; i < 8; i++) begin
      A = seq4_a[i];
      tick();
      check_eq($sformatf("b2b_%0d", i), Y, seq4_y[i]);
    end

    // 5: one-cycle reset pulse mid-operation.
    A = 2'b10;
    tick();
    check_eq("pulse_before", Y, 4'b0100);
    rst = 1'b1;
    tick();
    check_eq("pulse_rst", Y, 4'b0000);
    rst = 1'b0;
    tick();
    check_eq("pulse_after", Y, 4'b0100);

    // 6: enable dropped for one cycle.
    A = 2'b01;
    tick();
    check_eq("en_drop_before", Y, 4'b0010);
    E = 1'b0;
    tick();
    check_eq("en_drop_low", Y, 4'b0000);
    E = 1'b1;
    tick();
    check_eq("en_drop_restore", Y, 4'b0010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
